// File: rtl/arilla_bus_stall_gen.sv
// Generates the arilla bus `available` signal in one of four selectable stall modes:
// ready, periodic duty, LFSR random, or per-request wait states. Also has a liveness watchdog.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// PH_HIGH  | periodic: available high phase (also the restart state)
// PH_LOW   | periodic: available low phase
// PH_IDLE  | wait-state: no stall in progress, accepting requests
// PH_STALL | wait-state: holding available low for cfg_wait cycles
module arilla_bus_stall_gen #(
    parameter int          CountWidth  = 8,
    parameter int          LfsrWidth   = 16,
    parameter logic [31:0] LfsrSeed    = 32'h0000_ACE1,
    parameter int          DefaultMode = 1,
    parameter int          DefaultHi   = 4,
    parameter int          DefaultLo   = 4,
    parameter int          StatWidth   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_load,
    input  logic [1:0]            cfg_mode,
    input  logic [CountWidth-1:0] cfg_hi,
    input  logic [CountWidth-1:0] cfg_lo,
    input  logic [7:0]            cfg_threshold,
    input  logic [CountWidth-1:0] cfg_wait,
    input  logic [CountWidth-1:0] cfg_max_stall,
    input  logic                  req,
    output logic                  available,
    output logic [StatWidth-1:0]  stall_count,
    output logic                  watchdog_hit
);

    typedef enum logic [1:0] {
        PH_HIGH  = 2'd0,
        PH_LOW   = 2'd1,
        PH_IDLE  = 2'd2,
        PH_STALL = 2'd3
    } phase_t;

    localparam logic [1:0] ModeReady    = 2'd0;
    localparam logic [1:0] ModePeriodic = 2'd1;
    localparam logic [1:0] ModeRandom   = 2'd2;
    localparam logic [1:0] ModeWait     = 2'd3;

    localparam logic [LfsrWidth-1:0] Taps =
        (LfsrWidth == 32) ? LfsrWidth'(32'h8020_0003) : LfsrWidth'(32'h0000_B400);
    localparam logic [LfsrWidth-1:0] SeedRaw = LfsrWidth'(LfsrSeed);
    // An all-zero Galois LFSR never leaves zero, so a zero seed is promoted to 1.
    localparam logic [LfsrWidth-1:0] SeedEff = (SeedRaw == '0) ? LfsrWidth'(1) : SeedRaw;

    logic [1:0]            mode_q;
    logic [CountWidth-1:0] hi_q;
    logic [CountWidth-1:0] lo_q;
    logic [7:0]            thr_q;
    logic [CountWidth-1:0] wait_q;
    logic [CountWidth-1:0] max_stall_q;

    phase_t                phase_q;
    phase_t                phase_d;
    logic [CountWidth-1:0] cnt_q;
    logic [CountWidth-1:0] cnt_d;
    logic [CountWidth:0]   cnt_inc;
    logic [CountWidth-1:0] run_q;
    logic [CountWidth-1:0] run_next;
    logic [LfsrWidth-1:0]  lfsr_q;
    logic [LfsrWidth-1:0]  lfsr_next;
    logic                  mode_avail;
    logic                  wd_fire;
    logic                  avail_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= 2'(DefaultMode);
            hi_q         <= CountWidth'(DefaultHi);
            lo_q         <= CountWidth'(DefaultLo);
            thr_q        <= '0;
            wait_q       <= '0;
            max_stall_q  <= '0;
            phase_q      <= PH_HIGH;
            cnt_q        <= '0;
            run_q        <= '0;
            lfsr_q       <= SeedEff;
            available    <= 1'b1;
            watchdog_hit <= 1'b0;
            stall_count  <= '0;
        end else begin
            lfsr_q <= lfsr_next;
            if (!available && !(&stall_count)) begin
                stall_count <= stall_count + StatWidth'(1);
            end
            if (cfg_load) begin
                mode_q       <= cfg_mode;
                hi_q         <= cfg_hi;
                lo_q         <= cfg_lo;
                thr_q        <= cfg_threshold;
                wait_q       <= cfg_wait;
                max_stall_q  <= cfg_max_stall;
                phase_q      <= PH_HIGH;
                cnt_q        <= '0;
                run_q        <= '0;
                available    <= 1'b1;
                watchdog_hit <= 1'b0;
            end else begin
                phase_q      <= phase_d;
                cnt_q        <= cnt_d;
                run_q        <= run_next;
                available    <= avail_d;
                watchdog_hit <= wd_fire;
            end
        end
    end

    always_comb begin
        lfsr_next = {1'b0, lfsr_q[LfsrWidth-1:1]} ^ (lfsr_q[0] ? Taps : '0);

        run_next = '0;
        if (!available) begin
            run_next = (&run_q) ? run_q : run_q + CountWidth'(1);
        end
        wd_fire = (max_stall_q != '0) && (run_next >= max_stall_q);

        cnt_inc    = {1'b0, cnt_q} + (CountWidth + 1)'(1);
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        mode_avail = 1'b1;

        case (mode_q)
            ModeReady: begin
                mode_avail = 1'b1;
            end
            ModePeriodic: begin
                // Zero-length phases are skipped; with both zero we stay high.
                if (phase_q == PH_LOW) begin
                    if (cnt_inc < {1'b0, lo_q}) begin
                        cnt_d      = cnt_inc[CountWidth-1:0];
                        mode_avail = 1'b0;
                    end else if (hi_q != '0) begin
                        phase_d    = PH_HIGH;
                        cnt_d      = '0;
                        mode_avail = 1'b1;
                    end else begin
                        cnt_d      = '0;
                        mode_avail = 1'b0;
                    end
                end else begin
                    if (cnt_inc < {1'b0, hi_q}) begin
                        phase_d    = PH_HIGH;
                        cnt_d      = cnt_inc[CountWidth-1:0];
                        mode_avail = 1'b1;
                    end else if (lo_q != '0) begin
                        phase_d    = PH_LOW;
                        cnt_d      = '0;
                        mode_avail = 1'b0;
                    end else begin
                        phase_d    = PH_HIGH;
                        cnt_d      = '0;
                        mode_avail = 1'b1;
                    end
                end
            end
            ModeRandom: begin
                mode_avail = (lfsr_next[7:0] >= thr_q);
            end
            ModeWait: begin
                // A watchdog-forced cycle still advances the stall count.
                if (phase_q == PH_STALL) begin
                    if (cnt_inc < {1'b0, wait_q}) begin
                        cnt_d      = cnt_inc[CountWidth-1:0];
                        mode_avail = 1'b0;
                    end else begin
                        phase_d    = PH_IDLE;
                        cnt_d      = '0;
                        mode_avail = 1'b1;
                    end
                end else if (available && req && (wait_q != '0)) begin
                    phase_d    = PH_STALL;
                    cnt_d      = '0;
                    mode_avail = 1'b0;
                end else begin
                    phase_d    = PH_IDLE;
                    cnt_d      = '0;
                    mode_avail = 1'b1;
                end
            end
            default: begin
                mode_avail = 1'b1;
            end
        endcase

        avail_d = mode_avail | wd_fire;
    end

endmodule

// File: tb/tb_arilla_bus_stall_gen.sv
// Scoreboard bench for arilla_bus_stall_gen: per-cycle expectations are queued at drive
// time and compared one clock later against available, watchdog_hit and stall_count.
module tb_arilla_bus_stall_gen;

    localparam logic [15:0] Seed = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_load = 1'b0;
    logic [1:0]  cfg_mode = '0;
    logic [7:0]  cfg_hi = '0;
    logic [7:0]  cfg_lo = '0;
    logic [7:0]  cfg_threshold = '0;
    logic [7:0]  cfg_wait = '0;
    logic [7:0]  cfg_max_stall = '0;
    logic        req = 1'b0;
    logic        available;
    logic [31:0] stall_count;
    logic        watchdog_hit;

    arilla_bus_stall_gen dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_load      (cfg_load),
        .cfg_mode      (cfg_mode),
        .cfg_hi        (cfg_hi),
        .cfg_lo        (cfg_lo),
        .cfg_threshold (cfg_threshold),
        .cfg_wait      (cfg_wait),
        .cfg_max_stall (cfg_max_stall),
        .req           (req),
        .available     (available),
        .stall_count   (stall_count),
        .watchdog_hit  (watchdog_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        avail;
        logic        wd;
        logic [31:0] sc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] m_lfsr = Seed;
    logic [31:0] exp_sc = '0;
    logic        cur_exp = 1'b1;
    int          rnd_hits = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Queue the expectation for the cycle after the next edge, clock, then check it.
    task automatic cyc(input logic ea, input logic ew);
        exp_t e;
        e.avail = ea;
        e.wd    = ew;
        e.sc    = rst ? 32'd0 : (cur_exp ? exp_sc : exp_sc + 32'd1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        m_lfsr = rst ? Seed : lfsr_step(m_lfsr);
        e = exp_q.pop_front();
        check_val("available", {31'd0, available}, {31'd0, e.avail});
        check_val("watchdog_hit", {31'd0, watchdog_hit}, {31'd0, e.wd});
        check_val("stall_count", stall_count, e.sc);
        exp_sc  = e.sc;
        cur_exp = e.avail;
    endtask

    task automatic load(input logic [1:0] m, input logic [7:0] h, input logic [7:0] l,
                        input logic [7:0] t, input logic [7:0] w, input logic [7:0] ms);
        cfg_mode      = m;
        cfg_hi        = h;
        cfg_lo        = l;
        cfg_threshold = t;
        cfg_wait      = w;
        cfg_max_stall = ms;
        cfg_load      = 1'b1;
        cyc(1'b1, 1'b0);
        cfg_load      = 1'b0;
    endtask

    initial begin
        logic [15:0] nl;
        logic        ea;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_lfsr  = Seed;
        exp_sc  = '0;
        cur_exp = 1'b1;
        check_val("reset_available", {31'd0, available}, 32'd1);
        check_val("reset_stall_count", stall_count, 32'd0);
        check_val("reset_watchdog_hit", {31'd0, watchdog_hit}, 32'd0);

        // Default periodic 4/4
        for (int i = 1; i <= 16; i++) begin
            cyc((i % 8) < 4, 1'b0);
            if (i == 8) check_val("sc_after_8", stall_count, 32'd4);
        end

        // hi=2, lo=0: constantly available
        load(2'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0);
        repeat (100) cyc(1'b1, 1'b0);

        // Wait-state mode, wait=3, with a repeated request during the stall
        load(2'd3, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0);
        for (int k = 0; k < 2; k++) begin
            req = 1'b1;
            cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b0);
            req = 1'b0;
            cyc(1'b1, 1'b0);
            cyc(1'b1, 1'b0);
        end

        // hi=0, lo=5, max_stall=3: watchdog breaks every third stall cycle
        load(2'd1, 8'd0, 8'd5, 8'd0, 8'd0, 8'd3);
        for (int i = 0; i < 12; i++) begin
            if ((i % 4) == 3) cyc(1'b1, 1'b1);
            else              cyc(1'b0, 1'b0);
        end

        // Random mode, threshold 0 and 255
        load(2'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        repeat (20) cyc(1'b1, 1'b0);
        load(2'd2, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0);
        for (int i = 0; i < 3000; i++) begin
            nl = lfsr_step(m_lfsr);
            ea = (nl[7:0] == 8'hFF);
            if (ea) rnd_hits++;
            cyc(ea, 1'b0);
        end
        check_val("rnd_hits_seen", {31'd0, (rnd_hits > 0)}, 32'd1);

        // Reset in the middle of a LOW phase
        load(2'd1, 8'd4, 8'd4, 8'd0, 8'd0, 8'd0);
        for (int i = 1; i <= 5; i++) cyc(i < 4, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) cyc(i < 4, 1'b0);

        // Reset in the middle of a wait-state stall
        load(2'd3, 8'd0, 8'd0, 8'd0, 8'd5, 8'd0);
        req = 1'b1;
        cyc(1'b0, 1'b0);
        req = 1'b0;
        cyc(1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) cyc(i < 4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arilla_bus_stall_gen.md
Name: arilla_bus_stall_gen

Overview:
- Parametrised generator for the arilla bus `available` signal. It replaces the fixed 4-cycle-on/4-cycle-off availability toggle used in simulation benches.
- Supports four runtime-selectable stall modes: always-ready, periodic duty, pseudo-random and per-request wait states.
- Includes a liveness watchdog and a saturating stall counter.
- Drives `bus_interface.available` in system benches and in the FPGA stress build, alongside rv_core and memory.

Parameters:
- CountWidth, 8, width of the hi/lo/wait/max-stall cycle count fields.
- LfsrWidth, 16, LFSR width for random mode; legal values 16 or 32.
- LfsrSeed, 16'hACE1, LFSR reset value; zero is replaced by 1.
- DefaultMode, 1, mode loaded at reset (0 ready, 1 periodic, 2 random, 3 wait-state).
- DefaultHi, 4, reset value of hi_cycles.
- DefaultLo, 4, reset value of lo_cycles.
- StatWidth, 32, width of stall_count.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_load  input  1  one-cycle strobe that latches all cfg_* inputs.
- cfg_mode  input  2  mode select.
- cfg_hi  input  CountWidth  periodic-mode available-high length, in cycles.
- cfg_lo  input  CountWidth  periodic-mode available-low length, in cycles.
- cfg_threshold  input  8  random-mode threshold.
- cfg_wait  input  CountWidth  wait-state mode stall length per request.
- cfg_max_stall  input  CountWidth  watchdog limit; 0 disables the watchdog.
- req  input  1  bus request/strobe currently presented by the master.
- available  output  1  registered bus availability.
- stall_count  output  StatWidth  count of cycles with available=0; saturates at all-ones.
- watchdog_hit  output  1  one-cycle pulse when the watchdog forces available high.

Behaviour:
- Reset (rst=1 at a clock edge):
  - available=1, stall_count=0, watchdog_hit=0, phase=HIGH, phase counter=0, stall-run counter=0.
  - lfsr=LfsrSeed (zero replaced by 1).
  - Config registers take their defaults: mode=DefaultMode, hi=DefaultHi, lo=DefaultLo, threshold=0, wait=0, max_stall=0.
  - Reset asserted mid-pattern aborts the pattern immediately.
- Config load:
  - cfg_load=1 latches the config at that edge and restarts the pattern: phase=HIGH, counters cleared, available=1 on the following cycle.
  - The LFSR is not reseeded.
- All modes compute next_available; available is its register, so there is 1-cycle latency from the internal decision.
- Mode 0 (ready): available=1 constantly.
- Mode 1 (periodic):
  - States HIGH and LOW. HIGH holds available=1 for hi cycles, then transitions to LOW; LOW holds available=0 for lo cycles, then returns to HIGH.
  - A phase with length 0 is skipped.
  - hi=0 and lo=0 gives constant available=1.
  - hi=0 and lo>0 gives constant available=0, subject to the watchdog.
- Mode 2 (random):
  - Galois LFSR advances every cycle regardless of mode. Taps: 0xB400 for 16-bit, 0x80200003 for 32-bit.
  - available = (lfsr[7:0] >= threshold). threshold=0 means always 1.
- Mode 3 (wait-state):
  - States IDLE and STALL.
  - In IDLE with available=1, req=1 and wait>0: next cycle enters STALL with available=0 for exactly wait cycles, then returns to IDLE with available=1.
  - req while in STALL is ignored.
  - wait=0 means never stall.
- Watchdog:
  - Stall-run counter increments each cycle available=0 and clears when available=1.
  - When max_stall≠0 and the counter reaches max_stall, next cycle forces available=1 for one cycle and pulses watchdog_hit.
  - The mode pattern then continues: phase counters are not reset, and the forced cycle counts as part of the pattern.
- stall_count: +1 per cycle with available=0; holds at 2^StatWidth−1.
- Simultaneous events:
  - rst takes priority over cfg_load.
  - cfg_load takes priority over the watchdog and the mode logic.
  - A watchdog force overrides a mode-3 STALL cycle without shortening the remaining wait count.

Test Plan:
- Reset then idle with default periodic 4/4 -> available pattern 1,1,1,1,0,0,0,0 repeating; stall_count=4 after 8 cycles post-reset.
- cfg_load mode=1, hi=2, lo=0 -> available stays 1 for 100 cycles; stall_count unchanged.
- cfg_load mode=3, wait=3; pulse req while available=1 -> available 0 for exactly 3 cycles starting the next cycle, then 1; a second req during the stall has no effect.
- cfg_load mode=1, hi=0, lo=5, max_stall=3 -> available 0,0,0,1(watchdog_hit=1),0,0,0,1,...
- Mode 2: threshold=0 -> always 1. threshold=255 -> available=1 only on cycles with lfsr[7:0]=0xFF; those cycles must match a reference-model LFSR seeded with 0xACE1.
- Assert rst in the middle of a LOW phase and in the middle of a mode-3 stall -> the next cycle shows available=1, stall_count=0 and mode=DefaultMode.
